bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master (IFU/LSU) round-robin arbiter onto a single valid/ready memory slave.
// One outstanding transaction at a time; a per-transaction watchdog aborts a stalled slave with an error.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        s_req_valid,
  input  logic        s_req_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic        s_wen,
  output logic [3:0]  s_wstrb,
  input  logic        s_resp_valid,
  output logic        s_resp_ready,
  input  logic [31:0] s_rdata,
  input  logic        s_err,
  output logic [1:0]  grant,
  output logic        busy
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP, ST_ERR} state_t;

  state_t           r_state;
  state_t           w_nxt_state;
  logic             r_gnt_lsu;
  logic             r_last_lsu;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_wen;
  logic [3:0]       r_wstrb;
  logic [CNT_W-1:0] r_cnt;

  logic w_pick_lsu;
  logic w_accept;
  logic w_done;
  logic w_m_resp_ready;
  logic w_timeout;

  // LSU wins when alone, or on a tie when IFU was served last.
  assign w_pick_lsu     = lsu_req_valid && (!ifu_req_valid || r_last_lsu == 1'b0);
  assign w_m_resp_ready = r_gnt_lsu ? lsu_resp_ready : ifu_resp_ready;
  assign w_timeout      = (r_cnt == CNT_LAST);

  // State register plus the request latch, watchdog and round-robin history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_gnt_lsu  <= 1'b0;
      r_last_lsu <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_wen      <= 1'b0;
      r_wstrb    <= 4'd0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_nxt_state;
      if (w_accept) begin
        r_gnt_lsu <= w_pick_lsu;
        r_cnt     <= '0;
        if (w_pick_lsu) begin
          r_addr  <= lsu_addr;
          r_wdata <= lsu_wdata;
          r_wen   <= lsu_wen;
          r_wstrb <= lsu_wstrb;
        end else begin
          r_addr  <= ifu_addr;
          r_wdata <= 32'd0;
          r_wen   <= 1'b0;
          r_wstrb <= 4'd0;
        end
      end else if (r_state == ST_REQ || r_state == ST_RESP) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_done) begin
        r_last_lsu <= r_gnt_lsu;
      end
    end
  end

  // Next-state and all handshake/data outputs.
  always_comb begin
    w_nxt_state    = r_state;
    w_accept       = 1'b0;
    w_done         = 1'b0;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = 32'd0;
    ifu_err        = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = 32'd0;
    lsu_err        = 1'b0;
    s_req_valid    = 1'b0;
    s_addr         = 32'd0;
    s_wdata        = 32'd0;
    s_wen          = 1'b0;
    s_wstrb        = 4'd0;
    s_resp_ready   = 1'b0;
    grant          = 2'b00;
    busy           = 1'b0;

    if (r_state != ST_IDLE) begin
      grant = r_gnt_lsu ? 2'b10 : 2'b01;
      busy  = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        // Reset gating keeps req_ready low while reset is held.
        if (!reset && (ifu_req_valid || lsu_req_valid)) begin
          w_accept    = 1'b1;
          w_nxt_state = ST_REQ;
          if (w_pick_lsu) lsu_req_ready = 1'b1;
          else            ifu_req_ready = 1'b1;
        end
      end
      ST_REQ: begin
        s_req_valid = 1'b1;
        s_addr      = r_addr;
        s_wdata     = r_wdata;
        s_wen       = r_wen;
        s_wstrb     = r_wstrb;
        if (s_req_ready)    w_nxt_state = ST_RESP;
        else if (w_timeout) w_nxt_state = ST_ERR;
      end
      ST_RESP: begin
        s_resp_ready = w_m_resp_ready;
        if (r_gnt_lsu) begin
          lsu_resp_valid = s_resp_valid;
          lsu_rdata      = s_rdata;
          lsu_err        = s_err;
        end else begin
          ifu_resp_valid = s_resp_valid;
          ifu_rdata      = s_rdata;
          ifu_err        = s_err;
        end
        if (s_resp_valid && w_m_resp_ready) begin
          w_done      = 1'b1;
          w_nxt_state = ST_IDLE;
        end else if (w_timeout) begin
          w_nxt_state = ST_ERR;
        end
      end
      ST_ERR: begin
        if (r_gnt_lsu) begin
          lsu_resp_valid = 1'b1;
          lsu_err        = 1'b1;
        end else begin
          ifu_resp_valid = 1'b1;
          ifu_err        = 1'b1;
        end
        if (w_m_resp_ready) begin
          w_done      = 1'b1;
          w_nxt_state = ST_IDLE;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: tie-break, store path, stalled fetch response,
// watchdog abort, round-robin alternation and mid-transaction reset.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wstrb;
  logic        s_req_valid, s_req_ready, s_wen, s_resp_valid, s_resp_ready, s_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        busy;

  int errors = 0;
  int checks = 0;

  bus_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .ifu_err(ifu_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .lsu_err(lsu_err),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wen(s_wen), .s_wstrb(s_wstrb), .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
    .s_rdata(s_rdata), .s_err(s_err), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Inputs change at the falling edge; outputs are checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_resp_ready = 0;
    s_req_ready = 0; s_resp_valid = 0; s_rdata = 0; s_err = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    ifu_req_valid = 1; lsu_req_valid = 1;
    #1;
    checks++; if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin errors++;
      $display("FAIL reset_req_ready got=%b%b exp=00", ifu_req_ready, lsu_req_ready); end
    checks++; if (grant !== 2'b00 || busy !== 1'b0 || s_req_valid !== 1'b0 || s_resp_ready !== 1'b0) begin errors++;
      $display("FAIL reset_outputs grant=%b busy=%b s_req_valid=%b s_resp_ready=%b exp all 0", grant, busy, s_req_valid, s_resp_ready); end
    step();
  endtask

  task automatic test_tie();
    reset = 1'b0;
    #1;
    checks++; if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin errors++;
      $display("FAIL tie_first_winner lsu_rdy=%b ifu_rdy=%b exp lsu_rdy=1 ifu_rdy=0", lsu_req_ready, ifu_req_ready); end
    step();
    lsu_req_valid = 0; s_req_ready = 1;
    #1;
    checks++; if (grant !== 2'b10 || ifu_req_ready !== 1'b0) begin errors++;
      $display("FAIL tie_grant_lsu grant=%b ifu_rdy=%b exp 10/0", grant, ifu_req_ready); end
    step();
    s_resp_valid = 1; lsu_resp_ready = 1;
    #1;
    checks++; if (lsu_resp_valid !== 1'b1) begin errors++;
      $display("FAIL tie_lsu_resp got=%b exp=1", lsu_resp_valid); end
    step();
    s_resp_valid = 0; lsu_resp_ready = 0;
    #1;
    checks++; if (ifu_req_ready !== 1'b1 || grant !== 2'b00) begin errors++;
      $display("FAIL tie_ifu_next ifu_rdy=%b grant=%b exp 1/00", ifu_req_ready, grant); end
    step();
    ifu_req_valid = 0;
    #1;
    checks++; if (grant !== 2'b01) begin errors++;
      $display("FAIL tie_grant_ifu got=%b exp=01", grant); end
    step();
    s_resp_valid = 1; ifu_resp_ready = 1;
    step();
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL tie_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_store();
    lsu_req_valid = 1; lsu_addr = 32'h8000_0010; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF;
    lsu_wstrb = 4'b0011; s_req_ready = 1;
    #1;
    checks++; if (lsu_req_ready !== 1'b1) begin errors++;
      $display("FAIL store_accept got=%b exp=1", lsu_req_ready); end
    step();
    // Scramble master fields: the latched copy must be what reaches the slave.
    lsu_req_valid = 0; lsu_addr = 32'h1111_1111; lsu_wen = 0; lsu_wdata = 32'h2222_2222; lsu_wstrb = 4'hF;
    #1;
    checks++; if (s_req_valid !== 1'b1 || s_addr !== 32'h8000_0010 || s_wdata !== 32'hDEAD_BEEF
                  || s_wen !== 1'b1 || s_wstrb !== 4'b0011) begin errors++;
      $display("FAIL store_slave_req v=%b a=%h d=%h w=%b s=%b exp 1/80000010/deadbeef/1/0011",
               s_req_valid, s_addr, s_wdata, s_wen, s_wstrb); end
    step();
    s_resp_valid = 1; lsu_resp_ready = 1;
    #1;
    checks++; if (lsu_resp_valid !== 1'b1 || ifu_resp_valid !== 1'b0 || s_resp_ready !== 1'b1 || s_req_valid !== 1'b0) begin errors++;
      $display("FAIL store_resp lsu_v=%b ifu_v=%b s_rr=%b s_rv=%b exp 1/0/1/0", lsu_resp_valid, ifu_resp_valid, s_resp_ready, s_req_valid); end
    step();
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b0 || grant !== 2'b00) begin errors++;
      $display("FAIL store_done busy=%b grant=%b exp 0/00", busy, grant); end
  endtask

  task automatic test_fetch_stall();
    ifu_req_valid = 1; ifu_addr = 32'h0000_0100; s_req_ready = 1;
    #1;
    checks++; if (ifu_req_ready !== 1'b1) begin errors++;
      $display("FAIL fetch_accept got=%b exp=1", ifu_req_ready); end
    step();
    ifu_req_valid = 0;
    #1;
    checks++; if (s_req_valid !== 1'b1 || s_addr !== 32'h100 || s_wen !== 1'b0 || s_wstrb !== 4'd0 || s_wdata !== 32'd0) begin errors++;
      $display("FAIL fetch_slave_req v=%b a=%h w=%b s=%b d=%h exp 1/100/0/0/0", s_req_valid, s_addr, s_wen, s_wstrb, s_wdata); end
    step();
    s_resp_valid = 1; s_rdata = 32'h0000_0013; ifu_resp_ready = 0; lsu_req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h13 || s_resp_ready !== 1'b0) begin errors++;
        $display("FAIL fetch_hold%0d v=%b d=%h s_rr=%b exp 1/13/0", i, ifu_resp_valid, ifu_rdata, s_resp_ready); end
      checks++; if (lsu_req_ready !== 1'b0 || lsu_resp_valid !== 1'b0 || lsu_rdata !== 32'd0 || grant !== 2'b01) begin errors++;
        $display("FAIL fetch_no_regrant%0d lsu_rdy=%b lsu_v=%b lsu_d=%h grant=%b exp 0/0/0/01", i, lsu_req_ready, lsu_resp_valid, lsu_rdata, grant); end
      step();
    end
    lsu_req_valid = 0; ifu_resp_ready = 1;
    #1;
    checks++; if (s_resp_ready !== 1'b1) begin errors++;
      $display("FAIL fetch_release s_rr=%b exp=1", s_resp_ready); end
    step();
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL fetch_done busy=%b exp=0", busy); end
  endtask

  task automatic test_timeout();
    int k;
    lsu_req_valid = 1; lsu_addr = 32'h4000_0000; s_req_ready = 0;
    step();
    lsu_req_valid = 0; s_rdata = 32'hCAFE_F00D;
    k = 0;
    #1;
    checks++; if (s_req_valid !== 1'b1 || lsu_resp_valid !== 1'b0) begin errors++;
      $display("FAIL timeout_entry s_rv=%b lsu_v=%b exp 1/0", s_req_valid, lsu_resp_valid); end
    while (k < 20 && lsu_resp_valid !== 1'b1) begin
      step();
      k++;
      #1;
    end
    checks++; if (k > 16 || lsu_resp_valid !== 1'b1) begin errors++;
      $display("FAIL timeout_latency cycles=%0d valid=%b exp <=16 and valid=1", k, lsu_resp_valid); end
    checks++; if (lsu_err !== 1'b1 || lsu_rdata !== 32'd0 || s_req_valid !== 1'b0 || s_resp_ready !== 1'b0
                  || ifu_resp_valid !== 1'b0 || grant !== 2'b10) begin errors++;
      $display("FAIL timeout_err err=%b d=%h s_rv=%b s_rr=%b ifu_v=%b grant=%b exp 1/0/0/0/0/10",
               lsu_err, lsu_rdata, s_req_valid, s_resp_ready, ifu_resp_valid, grant); end
    step();
    #1;
    checks++; if (lsu_resp_valid !== 1'b1 || lsu_err !== 1'b1) begin errors++;
      $display("FAIL timeout_hold v=%b err=%b exp 1/1", lsu_resp_valid, lsu_err); end
    lsu_resp_ready = 1;
    step();
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b0 || lsu_err !== 1'b0) begin errors++;
      $display("FAIL timeout_done busy=%b err=%b exp 0/0", busy, lsu_err); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    ifu_req_valid = 1; lsu_req_valid = 1; ifu_addr = 32'h10; lsu_addr = 32'h20;
    s_req_ready = 1; s_resp_valid = 1; ifu_resp_ready = 1; lsu_resp_ready = 1;
    exp_g = 2'b01;  // LSU was served last (timeout), so IFU wins this tie
    for (int t = 0; t < 10; t++) begin
      #1;
      checks++; if ({lsu_req_ready, ifu_req_ready} !== exp_g) begin errors++;
        $display("FAIL rr_ready%0d got=%b exp=%b", t, {lsu_req_ready, ifu_req_ready}, exp_g); end
      step();
      #1;
      checks++; if (grant !== exp_g) begin errors++;
        $display("FAIL rr_grant%0d got=%b exp=%b", t, grant, exp_g); end
      step();
      if (t == 9) begin ifu_req_valid = 0; lsu_req_valid = 0; end
      step();
      exp_g = ~exp_g;
    end
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL rr_done busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    ifu_req_valid = 1; ifu_addr = 32'h200; s_req_ready = 1;
    step();
    ifu_req_valid = 0;
    step();
    s_resp_valid = 1; s_rdata = 32'h5555_AAAA; ifu_resp_ready = 0;
    #1;
    checks++; if (ifu_resp_valid !== 1'b1) begin errors++;
      $display("FAIL rst_mid_pre v=%b exp=1", ifu_resp_valid); end
    reset = 1; ifu_req_valid = 1;
    #1;
    checks++; if (ifu_resp_valid !== 1'b0 || ifu_rdata !== 32'd0 || grant !== 2'b00 || busy !== 1'b0
                  || s_resp_ready !== 1'b0 || ifu_req_ready !== 1'b0 || s_req_valid !== 1'b0) begin errors++;
      $display("FAIL rst_mid_outputs v=%b d=%h grant=%b busy=%b s_rr=%b rdy=%b s_rv=%b exp all 0",
               ifu_resp_valid, ifu_rdata, grant, busy, s_resp_ready, ifu_req_ready, s_req_valid); end
    step();
    reset = 0; s_resp_valid = 0; s_req_ready = 0;
    #1;
    checks++; if (ifu_req_ready !== 1'b1 || ifu_resp_valid !== 1'b0) begin errors++;
      $display("FAIL rst_mid_regrant rdy=%b v=%b exp 1/0", ifu_req_ready, ifu_resp_valid); end
    step();
    ifu_req_valid = 0; s_req_ready = 1;
    #1;
    checks++; if (grant !== 2'b01 || s_req_valid !== 1'b1 || s_addr !== 32'h200) begin errors++;
      $display("FAIL rst_mid_req grant=%b s_rv=%b a=%h exp 01/1/200", grant, s_req_valid, s_addr); end
    step();
    s_resp_valid = 1; s_rdata = 32'h0000_0077; ifu_resp_ready = 1;
    #1;
    checks++; if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h77) begin errors++;
      $display("FAIL rst_mid_resp v=%b d=%h exp 1/77", ifu_resp_valid, ifu_rdata); end
    step();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_store();
    test_fetch_stall();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
